// File: rtl/progloader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader sits on the slave side; the byte source / memory model on the master side.
interface progloader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] waddr;
  logic [15:0] wdata;
  logic        we;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output waddr,
    output wdata,
    output we
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  waddr,
    input  wdata,
    input  we
  );
endinterface

// File: rtl/progloader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory, one word per 3 cycles.
// All outputs are registered; in_ready stalls indefinitely on in_valid=0, and drops for the WRITE cycle.
module progloader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  progloader_if.slave bus,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q;
  logic [7:0]  len_hi_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic [7:0]  hi_q;
  logic [7:0]  csum_q;

  logic        in_ready_q;
  logic        we_q;
  logic [15:0] waddr_q;
  logic [15:0] wdata_q;
  logic        cpu_hold_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  logic        xfer;
  logic [15:0] len_w;
  logic        len_bad;
  logic [15:0] cnt_inc;

  assign xfer    = bus.in_valid && in_ready_q;
  assign len_w   = {len_hi_q, bus.in_data};
  assign len_bad = (len_w == 16'd0) || (32'(len_w) > 32'(MAX_WORDS));
  assign cnt_inc = cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_hi_q   <= 8'd0;
      len_q      <= 16'd0;
      cnt_q      <= 16'd0;
      hi_q       <= 8'd0;
      csum_q     <= 8'd0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= 16'd0;
      wdata_q    <= 16'd0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q    <= S_LEN_HI;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            csum_q     <= 8'd0;
            cnt_q      <= 16'd0;
            busy_q     <= 1'b1;
            cpu_hold_q <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi_q <= bus.in_data;
            state_q  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_q <= len_w;
            if (len_bad) begin
              state_q    <= S_ERROR;
              err_q      <= 1'b1;
              busy_q     <= 1'b0;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (xfer) begin
            hi_q    <= bus.in_data;
            csum_q  <= csum_q ^ bus.in_data;
            state_q <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          // The write strobe is raised here so it is visible exactly during WRITE.
          if (xfer) begin
            csum_q     <= csum_q ^ bus.in_data;
            we_q       <= 1'b1;
            waddr_q    <= BASE_ADDR + cnt_q;
            wdata_q    <= {hi_q, bus.in_data};
            in_ready_q <= 1'b0;
            state_q    <= S_WRITE;
          end
        end
        S_WRITE: begin
          cnt_q      <= cnt_inc;
          in_ready_q <= 1'b1;
          state_q    <= (cnt_inc == len_q) ? S_CHECK : S_DATA_HI;
        end
        S_CHECK: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (bus.in_data == csum_q) begin
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
              state_q    <= S_DONE;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_ERROR;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          cpu_hold_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

  a_done_err_excl: assert property (@(posedge clk) disable iff (!rst) !(done_q && err_q));
  a_no_ready_in_write: assert property (@(posedge clk) disable iff (!rst) !(we_q && in_ready_q));

endmodule

// File: tb/tb_progloader.sv
// Two loaders (base 0000 and FFFF) share one randomized stream; writes are checked against a queue model.
module tb_progloader;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       cpu_hold0, busy0, done0, err0;
  logic       cpu_hold1, busy1, done1, err1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;

  logic [15:0] words[$];
  logic [31:0] cap0[$];
  logic [31:0] cap1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  progloader_if bus0 ();
  progloader_if bus1 ();

  assign bus0.in_valid = in_valid;
  assign bus0.in_data  = in_data;
  assign bus1.in_valid = in_valid;
  assign bus1.in_data  = in_data;

  progloader dut0 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus0.slave),
    .cpu_hold (cpu_hold0),
    .busy     (busy0),
    .done     (done0),
    .err      (err0)
  );

  progloader #(.BASE_ADDR(16'hFFFF)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus1.slave),
    .cpu_hold (cpu_hold1),
    .busy     (busy1),
    .done     (done1),
    .err      (err1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus0.we) begin
      cap0.push_back({bus0.waddr, bus0.wdata});
      chk("rdy_in_write0", 32'(bus0.in_ready), 32'd0);
    end
    if (bus1.we) cap1.push_back({bus1.waddr, bus1.wdata});
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"},   32'({bus0.in_ready, bus1.in_ready}), 32'd0);
    chk({tag, "_we"},    32'({bus0.we, bus1.we}), 32'd0);
    chk({tag, "_waddr"}, {bus0.waddr, bus1.waddr}, 32'd0);
    chk({tag, "_wdata"}, {bus0.wdata, bus1.wdata}, 32'd0);
    chk({tag, "_busy"},  32'({busy0, busy1}), 32'd0);
    chk({tag, "_done"},  32'({done0, done1}), 32'd0);
    chk({tag, "_err"},   32'({err0, err1}), 32'd0);
    chk({tag, "_hold"},  32'({cpu_hold0, cpu_hold1}), 32'd3);
  endtask

  // Entered and left at posedge+1.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    chk("start_busy", 32'({busy0, cpu_hold0, done0, err0}), 32'b1100);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit pulse_start);
    bit ok;
    ok = 1'b0;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = b;
    if (pulse_start) start = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus0.in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (!ok) chk("xfer_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_load(input logic [7:0] bad_xor, input bit gaps, input bit mid_start);
    logic [7:0]  cs;
    logic [15:0] nn;
    logic [31:0] e0, e1;
    int n, lat;
    bit good;
    n  = words.size();
    nn = 16'(n);
    cs = 8'd0;
    foreach (words[i]) cs = cs ^ words[i][15:8] ^ words[i][7:0];
    good = (bad_xor == 8'd0);
    cs   = cs ^ bad_xor;
    cap0.delete();
    cap1.delete();
    do_start();
    send_byte(nn[15:8], gaps, 1'b0);
    send_byte(nn[7:0], gaps, 1'b0);
    foreach (words[i]) begin
      send_byte(words[i][15:8], gaps, 1'b0);
      send_byte(words[i][7:0], gaps, mid_start && (i == 0));
    end
    send_byte(cs, gaps, 1'b0);
    for (int k = 0; k < 8 && !(done0 || err0); k++) begin @(posedge clk); #1; end
    lat = cyc - t0;
    chk("done",  32'({done0, done1}), good ? 32'd3 : 32'd0);
    chk("err",   32'({err0, err1}), good ? 32'd0 : 32'd3);
    chk("hold",  32'({cpu_hold0, cpu_hold1}), good ? 32'd0 : 32'd3);
    chk("busy",  32'({busy0, busy1}), 32'd0);
    chk("nwr0",  32'(cap0.size()), 32'(n));
    chk("nwr1",  32'(cap1.size()), 32'(n));
    for (int i = 0; i < n && i < cap0.size() && i < cap1.size(); i++) begin
      e0 = {16'(i), words[i]};
      e1 = {16'(16'hFFFF + 16'(i)), words[i]};
      chk("wr0", cap0[i], e0);
      chk("wr1", cap1[i], e1);
    end
    if (!gaps) chk("latency", 32'(lat), 32'(3 * n + 3));
  endtask

  task automatic bad_len(input logic [15:0] nn);
    cap0.delete();
    cap1.delete();
    do_start();
    send_byte(nn[15:8], 1'b0, 1'b0);
    send_byte(nn[7:0], 1'b0, 1'b0);
    chk("badlen_flags", 32'({err0, done0, busy0, cpu_hold0, bus0.in_ready}), 32'b10010);
    repeat (4) begin @(posedge clk); #1; end
    chk("badlen_held", 32'({err0, err1}), 32'd3);
    chk("badlen_nowr", 32'(cap0.size() + cap1.size()), 32'd0);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom()));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    words = '{16'h1234, 16'hABCD};
    run_load(8'h00, 1'b0, 1'b0);
    run_load(8'h01, 1'b0, 1'b0);

    bad_len(16'h0000);
    bad_len(16'h0401);
    bad_len(16'hFFFF);

    rand_words(3);
    run_load(8'h00, 1'b1, 1'b0);
    rand_words(4);
    run_load(8'h00, 1'b0, 1'b1);

    // Abort a load after one word has been written.
    rand_words(3);
    do_start();
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(words[0][15:8], 1'b0, 1'b0);
    send_byte(words[0][7:0], 1'b0, 1'b0);
    in_valid = 1'b1; in_data = words[1][15:8];
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("post_rst_idle", 32'({busy0, cpu_hold0, bus0.in_ready}), 32'b010);
    run_load(8'h00, 1'b0, 1'b0);

    rand_words(1024);
    run_load(8'h00, 1'b0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      rand_words(int'($urandom_range(1, 6)));
      run_load(($urandom_range(0, 2) == 0) ? 8'(1 + $urandom_range(0, 254)) : 8'h00,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
